// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Data has priority; a bounded run of data grants forces a waiting fetch through.
module rv32i_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [31:0]           if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [3:0]            d_be_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [31:0]           d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [31:0]           d_rdata_o,
    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_IF   = 2'd1,
        PEND_DL   = 2'd2
    } pend_e;

    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

    pend_e      pending_q, pending_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic       fetch_forced;

    assign fetch_forced = if_req_i && (run_cnt_q >= RUN_MAX);

    // Grants are suppressed while reset is held so nothing reaches memory.
    always_comb begin
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        if (!reset_i) begin
            if (d_req_i && !fetch_forced) begin
                d_gnt_o = 1'b1;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 4'b0000;
        if (d_gnt_o) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_we_o    = d_we_i ? d_be_i : 4'b0000;
        end else if (if_gnt_o) begin
            mem_addr_o = if_addr_i;
        end
    end

    assign mem_en_o = if_gnt_o | d_gnt_o;

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (if_gnt_o || !if_req_i) begin
            run_cnt_d = 4'd0;
        end else if (d_gnt_o && (run_cnt_q < RUN_MAX)) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end
    end

    // Stores leave nothing pending; only reads expect data next cycle.
    always_comb begin
        pending_d = PEND_NONE;
        if (if_gnt_o) begin
            pending_d = PEND_IF;
        end else if (d_gnt_o && !d_we_i) begin
            pending_d = PEND_DL;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q <= PEND_NONE;
            run_cnt_q <= 4'd0;
        end else begin
            pending_q <= pending_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign if_rvalid_o = (pending_q == PEND_IF);
    assign d_rvalid_o  = (pending_q == PEND_DL);
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Bench for rv32i_mem_arbiter: vector table for grants/memory strobes, scoreboard for read returns.
module tb_rv32i_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;

    rv32i_mem_arbiter #(.ADDR_WIDTH(32), .MAX_DATA_RUN(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'h0000_0013;
        return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Synchronous single-port memory, 1-cycle read latency, 256 words.
    logic        init_mem;
    logic [31:0] mem [256];
    logic [31:0] rdata_q;
    always @(posedge clk_i) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            rdata_q <= mem[mem_addr_o[9:2]];
        end
    end
    assign mem_rdata_i = rdata_q;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          due;
        logic        is_if;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        ifr;
        logic [31:0] ia;
        logic        dr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] da;
        logic [31:0] wd;
        logic        egi;
        logic        egd;
    } vec_t;

    logic [31:0] shadow [256];

    function automatic vec_t mk(logic ifr, logic [31:0] ia, logic dr, logic we, logic [3:0] be,
                                logic [31:0] da, logic [31:0] wd, logic egi, logic egd);
        vec_t v;
        v.ifr = ifr; v.ia = ia; v.dr = dr; v.we = we; v.be = be;
        v.da = da; v.wd = wd; v.egi = egi; v.egd = egd;
        return v;
    endfunction

    // Read-return monitor: one comparison per cycle against the scoreboard head.
    always @(negedge clk_i) begin
        logic [1:0]  exp_v;
        logic [31:0] exp_d;
        exp_v = 2'b00;
        exp_d = '0;
        while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_v = sb[0].is_if ? 2'b10 : 2'b01;
            exp_d = sb[0].data;
            void'(sb.pop_front());
        end
        checks++;
        if ({if_rvalid_o, d_rvalid_o} !== exp_v) begin
            errors++;
            $display("FAIL rvalid cyc=%0d got {if,d}=%b exp=%b", cyc, {if_rvalid_o, d_rvalid_o}, exp_v);
        end else if (exp_v != 2'b00) begin
            checks++;
            if ((exp_v[1] ? if_rdata_o : d_rdata_o) !== exp_d) begin
                errors++;
                $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc,
                         exp_v[1] ? if_rdata_o : d_rdata_o, exp_d);
            end
        end
    end

    task automatic apply(input vec_t v, input string name);
        logic [6:0]  exp_ctl, got_ctl;
        logic [63:0] exp_bus;
        if_req_i = v.ifr; if_addr_i = v.ia;
        d_req_i = v.dr; d_we_i = v.we; d_be_i = v.be; d_addr_i = v.da; d_wdata_i = v.wd;
        #1;
        exp_ctl = {v.egi, v.egd, v.egi | v.egd, (v.egd && v.we) ? v.be : 4'b0000};
        got_ctl = {if_gnt_o, d_gnt_o, mem_en_o, mem_we_o};
        exp_bus = v.egd ? {v.da, v.wd} : (v.egi ? {v.ia, 32'h0} : 64'h0);
        checks++;
        if (got_ctl !== exp_ctl) begin
            errors++;
            $display("FAIL %s cyc=%0d {ifg,dg,en,we} got=%b exp=%b", name, cyc, got_ctl, exp_ctl);
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o} !== exp_bus) begin
            errors++;
            $display("FAIL %s_bus cyc=%0d addr/wdata got=%h exp=%h", name, cyc,
                     {mem_addr_o, mem_wdata_o}, exp_bus);
        end
        if (v.egi) begin
            sb.push_back('{due: cyc + 1, is_if: 1'b1, data: shadow[v.ia[9:2]]});
        end else if (v.egd && !v.we) begin
            sb.push_back('{due: cyc + 1, is_if: 1'b0, data: shadow[v.da[9:2]]});
        end else if (v.egd && v.we) begin
            for (int b = 0; b < 4; b++)
                if (v.be[b]) shadow[v.da[9:2]][8*b +: 8] = v.wd[8*b +: 8];
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(posedge clk_i);
        #1;
        apply(v, name);
    endtask

    vec_t tbl[$];
    vec_t idle;

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        idle = mk(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0);

        tbl.push_back(mk(1, 32'h10, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0)); // lone fetch
        tbl.push_back(mk(0, 32'h0,  1, 1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 1)); // word store
        tbl.push_back(mk(0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0,        0, 1)); // load back
        tbl.push_back(mk(0, 32'h0,  1, 1, 4'h1, 32'h100, 32'h000000AA, 0, 1)); // byte store
        tbl.push_back(mk(0, 32'h0,  1, 0, 4'h0, 32'h100, 32'h0,        0, 1)); // reload
        tbl.push_back(idle);
        tbl.push_back(mk(0, 32'h0,  1, 0, 4'hF, 32'h20,  32'h12345678, 0, 1)); // load ignores be
        tbl.push_back(mk(1, 32'h8,  1, 0, 4'h0, 32'h24,  32'h0,        0, 1)); // contention: data wins
        tbl.push_back(mk(1, 32'h8,  0, 0, 4'h0, 32'h0,   32'h0,        1, 0)); // fetch follows
        tbl.push_back(mk(1, 32'hC,  1, 1, 4'h6, 32'h30,  32'h11223344, 0, 1)); // store under contention
        tbl.push_back(idle);

        reset_i  = 1'b1;
        init_mem = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h10;
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h20; d_wdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #2;
        checks++;
        if ({if_gnt_o, d_gnt_o, mem_en_o, mem_we_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_gnt got=%b exp=0000000", {if_gnt_o, d_gnt_o, mem_en_o, mem_we_o});
        end

        @(posedge clk_i);
        #1;
        reset_i  = 1'b0;
        init_mem = 1'b0;
        apply(mk(1, 32'h10, 1, 0, 4'h0, 32'h20, 32'h0, 0, 1), "post_reset");

        step(idle, "idle");
        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Continuous contention: four data grants then a forced fetch.
        for (int i = 0; i < 15; i++)
            step(mk(1, 32'h40 + 32'(4 * i), 1, 0, 4'h0, 32'h200 + 32'(4 * i), 32'h0,
                    (i % 5) == 4, (i % 5) != 4), $sformatf("starve%0d", i));
        step(idle, "idle");

        // A cycle without fetch request restarts the data run.
        for (int i = 0; i < 3; i++)
            step(mk(1, 32'h60, 1, 0, 4'h0, 32'h300, 32'h0, 0, 1), "run_a");
        step(mk(0, 32'h0, 1, 0, 4'h0, 32'h304, 32'h0, 0, 1), "run_clear");
        for (int i = 0; i < 5; i++)
            step(mk(1, 32'h64, 1, 0, 4'h0, 32'h308, 32'h0, i == 4, i != 4), $sformatf("run_b%0d", i));
        step(idle, "idle");

        // Data request drops exactly when the fetch would be forced anyway.
        for (int i = 0; i < 4; i++)
            step(mk(1, 32'h68, 1, 1, 4'hF, 32'h380, 32'hCAFE0000 + 32'(i), 0, 1), "force_d");
        step(mk(1, 32'h68, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0), "force_if");
        step(idle, "idle");

        // Back-to-back fetches, one per cycle.
        for (int i = 0; i < 8; i++)
            step(mk(1, 32'(4 * i), 0, 0, 4'h0, 32'h0, 32'h0, 1, 0), $sformatf("b2b%0d", i));
        step(idle, "idle");

        // Reset pulse between a fetch grant and its return.
        step(mk(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0), "pre_rst_fetch");
        #1;
        reset_i  = 1'b1;
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        sb.delete();
        #1;
        reset_i = 1'b0;
        step(idle, "post_pulse_idle");
        step(mk(1, 32'h14, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0), "refetch");
        step(idle, "idle");
        repeat (2) @(posedge clk_i);
        #2;

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain left=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Shares one single-port synchronous memory (1-cycle read latency) between the core's instruction-fetch port and its load/store port.
- Enables a unified imem/dmem SoC variant.
- Fixed data-over-fetch priority, with a starvation guard that forces a fetch grant after a bounded run of data grants.
- Routes read data back to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 32: byte-address width of both ports and the memory.
- MAX_DATA_RUN, 4: consecutive data grants allowed while a fetch is waiting; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous reset, active-high.
- if_req_i  in  1  fetch request; held with the address stable until granted.
- if_addr_i  in  ADDR_WIDTH  fetch byte address.
- if_gnt_o  out  1  fetch accepted this cycle.
- if_rvalid_o  out  1  fetch data valid.
- if_rdata_o  out  32  fetch data.
- d_req_i  in  1  data request; held until granted.
- d_we_i  in  1  1 = store, 0 = load.
- d_be_i  in  4  store byte enables.
- d_addr_i  in  ADDR_WIDTH  data byte address.
- d_wdata_i  in  32  store data.
- d_gnt_o  out  1  data accepted this cycle.
- d_rvalid_o  out  1  load data valid.
- d_rdata_o  out  32  load data.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  4  byte write enables; 0 for reads.
- mem_addr_o  out  ADDR_WIDTH  memory byte address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, valid the cycle after a read strobe.

Behaviour:
Arbitration (combinational, same cycle as requests):
- Exactly one grant per cycle at most; never both grants in one cycle.
- mem_en_o = if_gnt_o | d_gnt_o.
- Data access granted: mem_addr_o = d_addr_i, mem_wdata_o = d_wdata_i, mem_we_o = d_we_i ? d_be_i : 4'b0.
- Fetch access granted: mem_addr_o = if_addr_i, mem_we_o = 0, mem_wdata_o = 0.
- No grant: mem_we_o = 0; mem_addr_o and mem_wdata_o are don't-care (drive 0).
- Priority:
  - d_req_i only: data granted.
  - if_req_i only: fetch granted.
  - Both requesting and run_cnt_r < MAX_DATA_RUN: data granted.
  - Both requesting and run_cnt_r == MAX_DATA_RUN: fetch granted.

Starvation counter run_cnt_r (4 bits):
- Increments on each data grant made while if_req_i = 1.
- Clears on any fetch grant, or on any cycle with if_req_i = 0.
- Saturates at MAX_DATA_RUN.

Response tracking (pending_r ∈ {NONE, IF, DL}, registered):
- Next state is IF on a fetch grant, DL on a load grant, NONE otherwise. Store grants set NONE.
- if_rvalid_o = (pending_r == IF); d_rvalid_o = (pending_r == DL).
- if_rdata_o = d_rdata_o = mem_rdata_i (pass-through); consumers qualify with rvalid.
- Fully pipelined: a new grant is allowed in the same cycle as a previous read's rvalid, so throughput is 1 access/cycle.
- Stores produce no rvalid. Store-then-load to the same address returns the new data, because memory write precedes the read.

Latency:
- Request to grant: 0 cycles if the arbiter selects it.
- Grant to rvalid: 1 cycle.

Reset (asynchronous, active-high):
- pending_r = NONE, run_cnt_r = 0.
- All rvalid outputs 0. Grants and mem_en_o are 0 while reset_i = 1, regardless of requests.
- A read granted in the cycle reset asserts never returns rvalid, and the requester must re-request.
- After reset deasserts, the first arbitration occurs in the same cycle.

Boundary conditions:
- d_req_i deasserted in the same cycle a fetch is forced: no effect; the fetch is granted anyway.
- MAX_DATA_RUN = 1 yields strict alternation under continuous contention.

Test Plan:
- Reset: reset_i = 1 with both requests high → all grants, mem_en_o, and rvalids 0. Release → d_gnt_o = 1 in the same cycle; run_cnt_r starts counting.
- Lone fetch: if_req_i = 1, if_addr_i = 0x0000_0010, memory word = 0x0000_0013 → if_gnt_o, mem_en_o, and mem_addr_o = 0x10 that cycle. Next cycle if_rvalid_o = 1, if_rdata_o = 0x0000_0013, d_rvalid_o = 0.
- Store then load: store 0xDEADBEEF to 0x100 with be = 0xF, then load 0x100 → mem_we_o = 0xF on cycle 1, no rvalid. d_rvalid_o on cycle 3 with d_rdata_o = 0xDEADBEEF. Byte store be = 0x1 of 0x000000AA → reload reads 0xDEADBEAA.
- Starvation: both requests continuously high, MAX_DATA_RUN = 4 → grant sequence D,D,D,D,IF,D,D,D,D,IF… Never more than 4 consecutive D grants; never both grants in one cycle.
- Back-to-back: 8 consecutive fetches at 0x0,0x4,…,0x1C → 8 grants in 8 cycles; if_rvalid_o high for 8 consecutive cycles, each carrying the matching word.
- Reset mid-read: fetch granted, reset_i pulsed asynchronously before the next edge → if_rvalid_o stays 0; pending_r = NONE afterwards.
